// File: rtl/mmio_out_fifo.sv
// Memory-mapped output FIFO: DATA/STATUS/CTRL window drained by a valid/ready stream.
// Optional registered interrupt enabled by defining MMIO_OUT_FIFO_IRQ_EN.
module mmio_out_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          DEPTH     = 8,
  parameter int          AW        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] address,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
`ifdef MMIO_OUT_FIFO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] HALF_CNT = (AW+1)'(DEPTH / 2);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          ovf;
  logic          ovf_next;
  logic [1:0]    offset;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          wr_data;
  logic          flush;
  logic          ovf_clr;
  logic          ovf_set;
  logic          irq_bit;
  logic [31:0]   status;
  logic [1:0]    unused_addr;

  assign unused_addr = address[1:0];
  assign offset      = address[3:2];
  assign hit         = (address[31:4] == BASE_ADDR[31:4]) && (offset != 2'b11);

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  assign pop     = out_valid & out_ready;
  assign wr_data = we & hit & (offset == 2'b00);
  assign push    = wr_data & (!full | pop);
  assign ovf_set = wr_data & full & !pop;
  assign flush   = we & hit & (offset == 2'b10) & wd[0];
  assign ovf_clr = we & hit & (offset == 2'b10) & wd[1];

  // Flush wins over a same-cycle pop; push cannot coincide with flush.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Overflow beats a same-cycle clear.
  always_comb begin
    ovf_next = ovf;
    if (ovf_set) begin
      ovf_next = 1'b1;
    end else if (ovf_clr) begin
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      count <= count_next;
      ovf   <= ovf_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wd;
  end

`ifdef MMIO_OUT_FIFO_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= (count_next >= HALF_CNT) | ovf_next;
    end
  end
  assign irq_bit = irq;
`else
  logic [AW:0] unused_half;
  assign unused_half = HALF_CNT;
  assign irq_bit     = 1'b0;
`endif

  always_comb begin
    status          = '0;
    status[AW+4:4]  = count;
    status[3]       = irq_bit;
    status[2]       = ovf;
    status[1]       = full;
    status[0]       = empty;
  end

  always_comb begin
    rd = '0;
    if (hit) begin
      unique case (offset)
        2'b00:   rd = empty ? 32'h0 : mem[rd_ptr];
        2'b01:   rd = status;
        default: rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_out_fifo.sv
// Directed self-checking bench for mmio_out_fifo.
// Expected STATUS words are computed from the intended count/ovf state.
module tb_mmio_out_fifo;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] address;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        hit;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef MMIO_OUT_FIFO_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad   = 0;

  mmio_out_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .address   (address),
    .wd        (wd),
    .rd        (rd),
    .hit       (hit),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MMIO_OUT_FIFO_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st(input int cnt, input bit ov);
    logic [31:0] s;
    s      = 32'(cnt) << 4;
    s[2]   = ov;
    s[1]   = (cnt == 8);
    s[0]   = (cnt == 0);
`ifdef MMIO_OUT_FIFO_IRQ_EN
    s[3]   = (cnt >= 4) | ov;
`endif
    return s;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic r);
    address   = a;
    wd        = d;
    we        = 1'b1;
    out_ready = r;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, rd, exp);
  endtask

  initial begin
    reset     = 1'b1;
    we        = 1'b0;
    address   = '0;
    wd        = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    rd_chk("rst_status", BASE + 4, 32'h0000_0001);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_hit", 32'(hit), 1);
    rd_chk("rst_data", BASE, 0);

    // single push
    wr(BASE, 32'hDEAD_BEEF, 1'b0);
    chk("one_valid", 32'(out_valid), 1);
    chk("one_data", out_data, 32'hDEAD_BEEF);
    rd_chk("one_status", BASE + 4, 32'h0000_0010);
    rd_chk("one_rd_data", BASE, 32'hDEAD_BEEF);
    rd_chk("one_rd_again", BASE, 32'hDEAD_BEEF);
    wr(BASE + 8, 32'h1, 1'b0);
    rd_chk("flush1_status", BASE + 4, st(0, 0));

    // fill, overflow, drain
    for (int i = 1; i <= 8; i++) wr(BASE, 32'(i), 1'b0);
    rd_chk("full_status", BASE + 4, st(8, 0));
    wr(BASE, 32'd9, 1'b0);
    rd_chk("ovf_status", BASE + 4, st(8, 1));
    rd_chk("ovf_head", BASE, 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), out_data, 32'(i));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    chk("drained_valid", 32'(out_valid), 0);
    rd_chk("drained_status", BASE + 4, st(0, 1));
    wr(BASE + 8, 32'h2, 1'b0);
    rd_chk("ovfclr_status", BASE + 4, st(0, 0));

    // full with simultaneous pop
    for (int i = 1; i <= 8; i++) wr(BASE, 32'(i), 1'b0);
    wr(BASE, 32'd9, 1'b1);
    rd_chk("fullpop_status", BASE + 4, st(8, 0));
    for (int i = 2; i <= 9; i++) begin
      chk($sformatf("fp_drain_%0d", i), out_data, 32'(i));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    chk("fp_empty", 32'(out_valid), 0);

    // flush + ovf clear, undecoded offset
    for (int i = 1; i <= 3; i++) wr(BASE, 32'(i * 16), 1'b0);
    rd_chk("three_status", BASE + 4, st(3, 0));
    wr(BASE + 8, 32'h3, 1'b0);
    rd_chk("flush_status", BASE + 4, st(0, 0));
    chk("flush_valid", 32'(out_valid), 0);
    address = BASE + 12;
    wd      = 32'hFF;
    we      = 1'b1;
    #1;
    chk("off3_hit", 32'(hit), 0);
    chk("off3_rd", rd, 0);
    @(posedge clk);
    #1;
    we = 1'b0;
    rd_chk("off3_status", BASE + 4, st(0, 0));
    rd_chk("miss_rd", 32'h0000_0200, 0);

    // mid-stream reset
    wr(BASE, 32'hA, 1'b0);
    wr(BASE, 32'hB, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mrst_valid", 32'(out_valid), 0);
    rd_chk("mrst_status", BASE + 4, 32'h0000_0001);

`ifdef MMIO_OUT_FIFO_IRQ_EN
    chk("irq_rst", 32'(irq), 0);
    for (int i = 1; i <= 3; i++) wr(BASE, 32'(i), 1'b0);
    chk("irq_three", 32'(irq), 0);
    wr(BASE, 32'd4, 1'b0);
    chk("irq_four", 32'(irq), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("irq_pop", 32'(irq), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
